// File: rtl/cache_kv_controller_pkg.sv
// rtl/cache_kv_controller_pkg.sv - shared widths, operation codes, FSM states and entry layout
package if_types_pkg;

    localparam int KEY_WIDTH   = 16;
    localparam int VALUE_WIDTH = 64;

endpackage

package ctrl_types_pkg;

    import if_types_pkg::*;

    // Three bits wide so that undefined codes (4..7) can reach the controller and be rejected.
    typedef enum logic [2:0] {
        OP_NOOP   = 3'd0,
        OP_READ   = 3'd1,
        OP_UPSERT = 3'd2,
        OP_DELETE = 3'd3
    } operation_e;

    typedef enum logic [1:0] {
        CTRL_ST_IDLE    = 2'd0,
        CTRL_ST_LOOKUP  = 2'd1,
        CTRL_ST_EXECUTE = 2'd2,
        CTRL_ST_RESPOND = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic                   valid;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } entry_t;

endpackage

// File: rtl/cache_kv_controller_if.sv
// rtl/cache_kv_controller_if.sv - request/response bundle between the OBI cache interface and the controller
interface cache_kv_controller_if
    import ctrl_types_pkg::*;
#(
    parameter int KEY_WIDTH   = if_types_pkg::KEY_WIDTH,
    parameter int VALUE_WIDTH = if_types_pkg::VALUE_WIDTH
) ();

    operation_e             operation_in;
    logic [KEY_WIDTH-1:0]   key_in;
    logic [VALUE_WIDTH-1:0] value_in;
    logic                   ready_out;
    logic                   op_succ_out;
    logic [VALUE_WIDTH-1:0] value_out;

    // Master issues requests (the OBI front end); slave is the controller.
    modport master (
        output operation_in, key_in, value_in,
        input  ready_out, op_succ_out, value_out
    );

    modport slave (
        input  operation_in, key_in, value_in,
        output ready_out, op_succ_out, value_out
    );

endinterface

// File: rtl/cache_kv_controller_match.sv
// rtl/cache_kv_controller_match.sv - combinational parallel key compare and free-slot search
module cache_match_unit #(
    parameter int NUM_ENTRIES = 8,
    parameter int KEY_WIDTH   = if_types_pkg::KEY_WIDTH,
    localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic [KEY_WIDTH-1:0]                  key,
    input  logic [NUM_ENTRIES-1:0]                entry_valid,
    input  logic [NUM_ENTRIES-1:0][KEY_WIDTH-1:0] entry_keys,
    output logic                                  hit,
    output logic [IDX_W-1:0]                      hit_idx,
    output logic                                  free_valid,
    output logic [IDX_W-1:0]                      free_idx,
    output logic                                  full
);

    // Walk from the top slot down so the last assignment wins: free_idx ends on the lowest free slot.
    // Keys are unique among valid entries, so at most one compare can hit.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_valid = 1'b0;
        free_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!entry_valid[i]) begin
                free_valid = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (entry_valid[i] && (entry_keys[i] == key)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign full = &entry_valid;

endmodule

// File: rtl/cache_kv_controller.sv
// rtl/cache_kv_controller.sv - fixed-latency fully-associative key/value store behind the OBI cache interface
module cache_kv_controller
    import ctrl_types_pkg::*;
#(
    parameter int NUM_ENTRIES  = 8,
    parameter int KEY_WIDTH    = if_types_pkg::KEY_WIDTH,
    parameter int VALUE_WIDTH  = if_types_pkg::VALUE_WIDTH,
    localparam int IDX_W       = $clog2(NUM_ENTRIES),
    localparam int CNT_W       = $clog2(NUM_ENTRIES) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_kv_controller_if.slave bus,
    output logic [CNT_W-1:0]     entry_count_out
);

    ctrl_state_e            state_q, state_d;
    operation_e             op_q, op_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [VALUE_WIDTH-1:0] val_q, val_d;
    logic                   hit_q, hit_d;
    logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
    logic                   free_valid_q, free_valid_d;
    logic [IDX_W-1:0]       free_idx_q, free_idx_d;
    logic                   full_q, full_d;
    logic                   succ_q, succ_d;
    logic [VALUE_WIDTH-1:0] rdata_q, rdata_d;
    logic [IDX_W-1:0]       victim_q, victim_d;
    logic [CNT_W-1:0]       count_q, count_d;
    entry_t                 entries_q [NUM_ENTRIES];
    entry_t                 entries_d [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0]                entry_valid;
    logic [NUM_ENTRIES-1:0][KEY_WIDTH-1:0] entry_keys;
    logic                                  m_hit;
    logic [IDX_W-1:0]                      m_hit_idx;
    logic                                  m_free_valid;
    logic [IDX_W-1:0]                      m_free_idx;
    logic                                  m_full;

    // Flatten the store into the vectors the match unit compares against.
    always_comb begin
        entry_valid = '0;
        entry_keys  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            entry_valid[i] = entries_q[i].valid;
            entry_keys[i]  = entries_q[i].key;
        end
    end

    cache_match_unit #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .KEY_WIDTH   (KEY_WIDTH)
    ) u_match (
        .key         (key_q),
        .entry_valid (entry_valid),
        .entry_keys  (entry_keys),
        .hit         (m_hit),
        .hit_idx     (m_hit_idx),
        .free_valid  (m_free_valid),
        .free_idx    (m_free_idx),
        .full        (m_full)
    );

    // Next-state, request capture, lookup capture and store update for the one operation in flight.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        key_d        = key_q;
        val_d        = val_q;
        hit_d        = hit_q;
        hit_idx_d    = hit_idx_q;
        free_valid_d = free_valid_q;
        free_idx_d   = free_idx_q;
        full_d       = full_q;
        succ_d       = succ_q;
        rdata_d      = rdata_q;
        victim_d     = victim_q;
        count_d      = count_q;
        entries_d    = entries_q;

        case (state_q)
            CTRL_ST_IDLE: begin
                if (bus.operation_in != OP_NOOP) begin
                    op_d    = bus.operation_in;
                    key_d   = bus.key_in;
                    val_d   = bus.value_in;
                    state_d = CTRL_ST_LOOKUP;
                end
            end
            CTRL_ST_LOOKUP: begin
                hit_d        = m_hit;
                hit_idx_d    = m_hit_idx;
                free_valid_d = m_free_valid;
                free_idx_d   = m_free_idx;
                full_d       = m_full;
                state_d      = CTRL_ST_EXECUTE;
            end
            CTRL_ST_EXECUTE: begin
                succ_d  = 1'b0;
                rdata_d = '0;
                case (op_q)
                    OP_READ: begin
                        succ_d = hit_q;
                        if (hit_q) begin
                            rdata_d = entries_q[hit_idx_q].value;
                        end
                    end
                    OP_UPSERT: begin
                        succ_d = 1'b1;
                        if (hit_q) begin
                            entries_d[hit_idx_q].value = val_q;
                        end else if (!full_q && free_valid_q) begin
                            entries_d[free_idx_q] = '{valid: 1'b1, key: key_q, value: val_q};
                            count_d               = count_q + CNT_W'(1);
                        end else begin
                            // Round-robin eviction; the index width makes the pointer wrap on its own.
                            entries_d[victim_q] = '{valid: 1'b1, key: key_q, value: val_q};
                            victim_d            = victim_q + IDX_W'(1);
                        end
                    end
                    OP_DELETE: begin
                        if (hit_q) begin
                            entries_d[hit_idx_q].valid = 1'b0;
                            count_d                    = count_q - CNT_W'(1);
                            succ_d                     = 1'b1;
                        end
                    end
                    default: begin
                        succ_d = 1'b0;
                    end
                endcase
                state_d = CTRL_ST_RESPOND;
            end
            CTRL_ST_RESPOND: begin
                state_d = CTRL_ST_IDLE;
            end
            default: begin
                state_d = CTRL_ST_IDLE;
            end
        endcase
    end

    // State and storage registers; reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CTRL_ST_IDLE;
            op_q         <= OP_NOOP;
            key_q        <= '0;
            val_q        <= '0;
            hit_q        <= 1'b0;
            hit_idx_q    <= '0;
            free_valid_q <= 1'b0;
            free_idx_q   <= '0;
            full_q       <= 1'b0;
            succ_q       <= 1'b0;
            rdata_q      <= '0;
            victim_q     <= '0;
            count_q      <= '0;
            entries_q    <= '{default: '0};
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            key_q        <= key_d;
            val_q        <= val_d;
            hit_q        <= hit_d;
            hit_idx_q    <= hit_idx_d;
            free_valid_q <= free_valid_d;
            free_idx_q   <= free_idx_d;
            full_q       <= full_d;
            succ_q       <= succ_d;
            rdata_q      <= rdata_d;
            victim_q     <= victim_d;
            count_q      <= count_d;
            entries_q    <= entries_d;
        end
    end

    assign bus.ready_out   = (state_q == CTRL_ST_RESPOND);
    assign bus.op_succ_out = (state_q == CTRL_ST_RESPOND) ? succ_q : 1'b0;
    assign bus.value_out   = (state_q == CTRL_ST_RESPOND) ? rdata_q : '0;
    assign entry_count_out = count_q;

endmodule

// File: tb/tb_cache_kv_controller.sv
// tb/tb_cache_kv_controller.sv - directed self-checking bench for cache_kv_controller
module tb_cache_kv_controller;

    import ctrl_types_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] entry_count;
    int         n_checks;
    int         n_errors;

    cache_kv_controller_if bus ();

    cache_kv_controller #(.NUM_ENTRIES(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .entry_count_out (entry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents one op for one cycle and checks the t+3 response.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] key,
                         input logic [63:0] val, input logic exp_succ,
                         input logic [63:0] exp_val, input int exp_cnt);
        logic [2:0]  lat;
        logic        s;
        logic [63:0] v;
        bus.operation_in = operation_e'(op);
        bus.key_in       = key;
        bus.value_in     = val;
        @(negedge clk);
        lat[2]           = bus.ready_out;
        bus.operation_in = OP_NOOP;
        bus.key_in       = '0;
        bus.value_in     = '0;
        @(negedge clk);
        lat[1] = bus.ready_out;
        @(negedge clk);
        lat[0] = bus.ready_out;
        s      = bus.op_succ_out;
        v      = bus.value_out;
        check({tag, "_lat"}, 64'(lat), 64'(3'b001));
        check({tag, "_succ"}, 64'(s), 64'(exp_succ));
        check({tag, "_val"}, v, exp_val);
        check({tag, "_cnt"}, 64'(entry_count), 64'(exp_cnt));
        @(negedge clk);
        check({tag, "_idle"}, {61'd0, bus.ready_out, bus.op_succ_out, |bus.value_out}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        n_checks         = 0;
        n_errors         = 0;
        rst_n            = 1'b0;
        bus.operation_in = OP_NOOP;
        bus.key_in       = '0;
        bus.value_in     = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.ready_out), 64'd0);
        check("rst_succ", 64'(bus.op_succ_out), 64'd0);
        check("rst_value", bus.value_out, 64'd0);
        check("rst_count", 64'(entry_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("rd_empty", 3'd1, 16'h0012, 64'd0, 1'b0, 64'd0, 0);
        do_op("up_12", 3'd2, 16'h0012, 64'hDEADBEEF_CAFEF00D, 1'b1, 64'd0, 1);
        do_op("rd_12", 3'd1, 16'h0012, 64'd0, 1'b1, 64'hDEADBEEF_CAFEF00D, 1);
        do_op("up_12b", 3'd2, 16'h0012, 64'h1, 1'b1, 64'd0, 1);
        do_op("rd_12b", 3'd1, 16'h0012, 64'd0, 1'b1, 64'h1, 1);
        do_op("del_12", 3'd3, 16'h0012, 64'd0, 1'b1, 64'd0, 0);

        // Keys 1..8 land in slots 0..7.
        for (int k = 1; k <= 8; k++) begin
            do_op($sformatf("fill%0d", k), 3'd2, 16'(k), 64'h1000 + 64'(k), 1'b1, 64'd0, k);
        end
        do_op("evict9", 3'd2, 16'd9, 64'h1009, 1'b1, 64'd0, 8);
        do_op("rd_1_gone", 3'd1, 16'd1, 64'd0, 1'b0, 64'd0, 8);
        do_op("rd_9", 3'd1, 16'd9, 64'd0, 1'b1, 64'h1009, 8);

        do_op("del5", 3'd3, 16'd5, 64'd0, 1'b1, 64'd0, 7);
        do_op("del5_again", 3'd3, 16'd5, 64'd0, 1'b0, 64'd0, 7);
        do_op("up100", 3'd2, 16'd100, 64'h64, 1'b1, 64'd0, 8);
        do_op("rd_100", 3'd1, 16'd100, 64'd0, 1'b1, 64'h64, 8);

        // Victim pointer is at 1: keys 10..17 overwrite slots 1..7, then 0.
        for (int k = 10; k <= 17; k++) begin
            do_op($sformatf("evict%0d", k), 3'd2, 16'(k), 64'h1000 + 64'(k), 1'b1, 64'd0, 8);
        end
        do_op("rd_100_gone", 3'd1, 16'd100, 64'd0, 1'b0, 64'd0, 8);
        do_op("rd_9_gone", 3'd1, 16'd9, 64'd0, 1'b0, 64'd0, 8);
        do_op("rd_17", 3'd1, 16'd17, 64'd0, 1'b1, 64'h1011, 8);
        do_op("evict18", 3'd2, 16'd18, 64'h1012, 1'b1, 64'd0, 8);
        do_op("rd_10_gone", 3'd1, 16'd10, 64'd0, 1'b0, 64'd0, 8);
        do_op("rd_11", 3'd1, 16'd11, 64'd0, 1'b1, 64'h100B, 8);

        do_op("invalid7", 3'd7, 16'd11, 64'h5, 1'b0, 64'd0, 8);
        do_op("rd_11_post", 3'd1, 16'd11, 64'd0, 1'b1, 64'h100B, 8);

        // Reset while an UPSERT is in LOOKUP.
        bus.operation_in = OP_UPSERT;
        bus.key_in       = 16'h0030;
        bus.value_in     = 64'h77;
        @(negedge clk);
        bus.operation_in = OP_NOOP;
        rst_n            = 1'b0;
        #1;
        check("rst_mid_count", 64'(entry_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen = seen | bus.ready_out;
        end
        check("rst_mid_no_ready", 64'(seen), 64'd0);
        do_op("rd_30_after_rst", 3'd1, 16'h0030, 64'd0, 1'b0, 64'd0, 0);
        do_op("rd_11_after_rst", 3'd1, 16'd11, 64'd0, 1'b0, 64'd0, 0);

        // A DELETE pulsed during EXECUTE of an UPSERT must be ignored.
        bus.operation_in = OP_UPSERT;
        bus.key_in       = 16'h0020;
        bus.value_in     = 64'h55;
        @(negedge clk);
        bus.operation_in = OP_NOOP;
        @(negedge clk);
        bus.operation_in = OP_DELETE;
        bus.key_in       = 16'h0020;
        @(negedge clk);
        bus.operation_in = OP_NOOP;
        bus.key_in       = '0;
        bus.value_in     = '0;
        check("ign_ready", 64'(bus.ready_out), 64'd1);
        check("ign_succ", 64'(bus.op_succ_out), 64'd1);
        @(negedge clk);
        check("ign_idle_ready", 64'(bus.ready_out), 64'd0);
        do_op("rd_20", 3'd1, 16'h0020, 64'd0, 1'b1, 64'h55, 1);

        // Key 0 / value 0 are ordinary data.
        do_op("up_k0", 3'd2, 16'h0000, 64'h0, 1'b1, 64'd0, 2);
        do_op("rd_k0", 3'd1, 16'h0000, 64'd0, 1'b1, 64'd0, 2);
        do_op("del_k0", 3'd3, 16'h0000, 64'd0, 1'b1, 64'd0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_kv_controller.md
Name: cache_kv_controller

Overview:
- Controller stage directly downstream of the OBI cache interface.
- Consumes the decoded operation/key/value from the interface and executes it against a small fully-associative key-value store held in flops.
- Returns a one-cycle ready pulse, a success flag and read data, which the interface captures and forwards on its R channel.
- Fixed-latency, one operation in flight.

Parameters:
- NUM_ENTRIES, 8, number of key/value slots; power of two, ≥2.
- KEY_WIDTH, if_types_pkg::KEY_WIDTH, key bits per entry.
- VALUE_WIDTH, if_types_pkg::VALUE_WIDTH, value bits per entry.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- operation_in  in  ctrl_types_pkg::operation_e  requested op; non-NOOP for one cycle marks a request
- key_in  in  KEY_WIDTH  request key, valid with operation_in
- value_in  in  VALUE_WIDTH  write value, valid with operation_in
- ready_out  out  1  one-cycle pulse: result valid
- op_succ_out  out  1  operation succeeded; valid while ready_out=1
- value_out  out  VALUE_WIDTH  read data; valid while ready_out=1
- entry_count_out  out  $clog2(NUM_ENTRIES)+1  number of valid entries

Behaviour:
- Reset (async, any state):
  - all valid bits = 0; victim pointer = 0; state = IDLE.
  - ready_out = 0, op_succ_out = 0, value_out = 0, entry_count_out = 0.
  - An operation in flight is dropped with no response.
- Operation encoding (ctrl_types_pkg): NOOP=0, READ=1, UPSERT=2, DELETE=3. Any other code is INVALID.
- States:
  - IDLE: sample operation_in/key_in/value_in into request regs when operation_in != NOOP → LOOKUP. NOOP keeps IDLE.
  - LOOKUP: compare request key against all valid keys in parallel; register hit, hit_idx (at most one match by construction), lowest free index, full flag → EXECUTE.
  - EXECUTE: apply the op per the rules below; register op_succ and read data → RESPOND.
  - RESPOND: ready_out=1 for exactly this cycle; op_succ_out/value_out driven from registers → IDLE.
- Latency: op presented in cycle t → ready_out high in cycle t+3. Next op is accepted in cycle t+4 at the earliest.
- Inputs presented while not in IDLE are ignored.
- READ:
  - hit → succ=1, value_out = stored value.
  - miss → succ=0, value_out = 0.
- UPSERT (succ=1 always):
  - hit → overwrite value at hit_idx.
  - miss, not full → write key/value into lowest free index and set valid.
  - miss, full → overwrite the entry at the victim pointer; pointer increments mod NUM_ENTRIES, wrapping NUM_ENTRIES-1 → 0.
  - Victim pointer changes only on eviction.
- DELETE:
  - hit → clear valid, succ=1.
  - miss → succ=0; no state change.
- INVALID op: succ=0, value_out=0, no state change; still responds at t+3.
- For every op other than a successful READ, value_out = 0 during the RESPOND cycle.
- Outside RESPOND: ready_out=0, op_succ_out=0, value_out=0.
- entry_count_out:
  - updates the cycle after EXECUTE.
  - +1 on UPSERT into a free slot; −1 on DELETE hit; unchanged on eviction.
  - Never exceeds NUM_ENTRIES.
- Key 0 and value 0 are ordinary data, with no special meaning.

Decomposition:
- ctrl_types_pkg:
  - operation_e
  - ctrl_state_e (CTRL_ST_IDLE, CTRL_ST_LOOKUP, CTRL_ST_EXECUTE, CTRL_ST_RESPOND)
  - a packed entry struct {valid, key, value}
- if_types_pkg supplies KEY_WIDTH/VALUE_WIDTH defaults.
- One sub-module: cache_match_unit.
  - Purely combinational parallel compare of key against NUM_ENTRIES entries.
  - Outputs: hit, hit_idx, free_valid, free_idx (lowest), full.
  - Storage, FSM and replacement pointer stay in cache_kv_controller.

Test Plan:
- Reset then READ key 0x0012 → ready at t+3, op_succ=0, value_out=0, entry_count=0.
- UPSERT key 0x0012 value 0xDEADBEEF_CAFEF00D, then READ 0x0012 → both succ=1; the read returns 0xDEADBEEF_CAFEF00D; entry_count=1.
- UPSERT 0x0012 with 0x1, then READ → value 0x1, entry_count stays 1.
- Fill keys 1..8, then UPSERT key 9 → slot 0 evicted, READ 1 succ=0, READ 9 succ=1, entry_count=8.
- Repeat eviction 8 more times → victim pointer wraps to 0.
- DELETE 5 → succ=1, count 7; DELETE 5 again → succ=0.
- UPSERT key 100 → takes the freed slot 4 (lowest free), count 8.
- Invalid op code 7 → succ=0.
- Assert rst_n low during LOOKUP of an UPSERT → no ready pulse, store empty, entry_count=0.
- Pulse operation_in while in EXECUTE → input ignored.
